// File: rtl/subleq_mem_arbiter_if.sv
// subleq_mem_arbiter_if
// Bundles the two requester ports, the single-port memory bus and the
// status outputs of subleq_mem_arbiter.
//   m0_* / m1_* : requester ports (req/op/addr/wdata in, gnt/done/rdata out)
//   mem_*       : memory side (en/op/addr/write_bytes out, mem_data in)
//   busy        : arbiter is not idle
//   state_dbg   : raw FSM state, exported for checkers
// Modports: slave = arbiter view, master = requester + memory view.
interface subleq_mem_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              m0_req;
    logic              m0_op;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_done;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_op;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_done;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_en;
    logic              mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_bytes;
    logic [DATA_W-1:0] mem_data;

    logic              busy;
    logic [1:0]        state_dbg;

    modport slave (
        input  m0_req, m0_op, m0_addr, m0_wdata,
        input  m1_req, m1_op, m1_addr, m1_wdata,
        input  mem_data,
        output m0_gnt, m0_done, m0_rdata,
        output m1_gnt, m1_done, m1_rdata,
        output mem_en, mem_op, mem_addr, mem_write_bytes,
        output busy, state_dbg
    );

    modport master (
        output m0_req, m0_op, m0_addr, m0_wdata,
        output m1_req, m1_op, m1_addr, m1_wdata,
        output mem_data,
        input  m0_gnt, m0_done, m0_rdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  mem_en, mem_op, mem_addr, mem_write_bytes,
        input  busy, state_dbg
    );
endinterface

// File: rtl/subleq_mem_arbiter.sv
// subleq_mem_arbiter
// Round-robin arbiter sharing one single-port word memory between the subleq
// cpu (port 0) and the loader/debug port (port 1). One transaction in flight.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : subleq_mem_arbiter_if.slave (requesters, memory, busy)
//
// Handshake: a requester raises mX_req with op/addr/wdata stable and holds
// them until the cycle mX_gnt is high; mX_gnt is a one-cycle acceptance
// pulse. mX_done is a one-cycle completion pulse; on reads mX_rdata is valid
// in that cycle and holds until the port's next read completes. Requests are
// only sampled in IDLE or FINISH; a request dropped before then is ignored.
module subleq_mem_arbiter #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    subleq_mem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;
    localparam logic [3:0] LAT       = 4'(MEM_LATENCY);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_last_q, rd_last_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_op_q, mem_op_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wb_q, mem_wb_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              win;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        rd_last_d  = rd_last_q;
        mem_en_d   = 1'b0;
        mem_op_d   = mem_op_q;
        mem_addr_d = mem_addr_q;
        mem_wb_d   = mem_wb_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        // On a tie the port that was not granted last wins.
        if (bus.m0_req && bus.m1_req) begin
            win = ~last_gnt_q;
        end else begin
            win = bus.m1_req;
        end

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (bus.m0_req || bus.m1_req) begin
                    owner_d    = win;
                    last_gnt_d = win;
                    mem_en_d   = 1'b1;
                    mem_op_d   = win ? bus.m1_op    : bus.m0_op;
                    mem_addr_d = win ? bus.m1_addr  : bus.m0_addr;
                    mem_wb_d   = win ? bus.m1_wdata : bus.m0_wdata;
                    gnt0_d     = ~win;
                    gnt1_d     = win;
                    cnt_d      = LAT;
                    rd_last_d  = 1'b0;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // mem_op_q still holds the op of the transaction in flight.
                if (mem_op_q) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = ST_FINISH;
                end else if (rd_last_q) begin
                    // mem_data is valid in this cycle; done rises with rdata.
                    if (owner_q) begin
                        rdata1_d = bus.mem_data;
                    end else begin
                        rdata0_d = bus.mem_data;
                    end
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = ST_FINISH;
                end else if (cnt_q == 4'd1) begin
                    // Latency elapsed; data arrives in the next cycle.
                    rd_last_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            cnt_q      <= 4'd0;
            rd_last_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_op_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wb_q   <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            rd_last_q  <= rd_last_d;
            mem_en_q   <= mem_en_d;
            mem_op_q   <= mem_op_d;
            mem_addr_q <= mem_addr_d;
            mem_wb_q   <= mem_wb_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.m0_gnt          = gnt0_q;
    assign bus.m1_gnt          = gnt1_q;
    assign bus.m0_done         = done0_q;
    assign bus.m1_done         = done1_q;
    assign bus.m0_rdata        = rdata0_q;
    assign bus.m1_rdata        = rdata1_q;
    assign bus.mem_en          = mem_en_q;
    assign bus.mem_op          = mem_op_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_write_bytes = mem_wb_q;
    assign bus.busy            = busy_q;
    assign bus.state_dbg       = state_q;
endmodule

// File: tb/tb_subleq_mem_arbiter.sv
`timescale 1ns/1ps
module tb_subleq_mem_arbiter;
    localparam int NI = 3;
    localparam int W  = 64;
    localparam int L0 = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst [NI];

    // ---------------- per-instance stimulus / observation ----------------
    logic         req_i   [NI][2];
    logic         op_i    [NI][2];
    logic [W-1:0] addr_i  [NI][2];
    logic [W-1:0] wdata_i [NI][2];
    logic         gnt_o   [NI][2];
    logic         done_o  [NI][2];
    logic [W-1:0] rdata_o [NI][2];
    logic         mem_en_o[NI];
    logic         mem_op_o[NI];
    logic         busy_o  [NI];
    logic [W-1:0] mem_addr_o[NI];
    logic [W-1:0] mem_wb_o  [NI];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] init_word(input int a);
        return (a == 5) ? 64'h2A : (64'h5A5A_0000_0000_1000 + 64'(a));
    endfunction

    // Instances with MEM_LATENCY 1, 3, 15, each with its own memory model.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 15);
        subleq_mem_arbiter_if #(.DATA_W(W), .ADDR_W(W)) bus ();
        subleq_mem_arbiter #(.DATA_W(W), .ADDR_W(W), .MEM_LATENCY(L)) u_dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus)
        );
        assign bus.m0_req   = req_i[g][0];
        assign bus.m0_op    = op_i[g][0];
        assign bus.m0_addr  = addr_i[g][0];
        assign bus.m0_wdata = wdata_i[g][0];
        assign bus.m1_req   = req_i[g][1];
        assign bus.m1_op    = op_i[g][1];
        assign bus.m1_addr  = addr_i[g][1];
        assign bus.m1_wdata = wdata_i[g][1];
        assign gnt_o[g][0]   = bus.m0_gnt;
        assign gnt_o[g][1]   = bus.m1_gnt;
        assign done_o[g][0]  = bus.m0_done;
        assign done_o[g][1]  = bus.m1_done;
        assign rdata_o[g][0] = bus.m0_rdata;
        assign rdata_o[g][1] = bus.m1_rdata;
        assign mem_en_o[g]   = bus.mem_en;
        assign mem_op_o[g]   = bus.mem_op;
        assign mem_addr_o[g] = bus.mem_addr;
        assign mem_wb_o[g]   = bus.mem_write_bytes;
        assign busy_o[g]     = bus.busy;

        logic [W-1:0] mem  [16];
        logic [W-1:0] pipe [16];
        initial begin
            for (int a = 0; a < 16; a++) begin
                mem[a]  = init_word(a);
                pipe[a] = 64'hCCCC_CCCC_CCCC_CCCC;
            end
        end
        // Read data appears L cycles after the mem_en cycle; poison otherwise.
        always @(posedge clk) begin
            if (bus.mem_en && bus.mem_op) mem[bus.mem_addr[3:0]] <= bus.mem_write_bytes;
            pipe[0] <= (bus.mem_en && !bus.mem_op) ? mem[bus.mem_addr[3:0]]
                                                   : 64'hCCCC_CCCC_CCCC_CCCC;
            for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
        end
        assign bus.mem_data = pipe[L-1];
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int           inst;
        int           port;
        logic         op;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        int           exp_done;   // cycle of done, req raised in cycle 0
        logic [W-1:0] exp_rdata;  // owner rdata at done
        logic [W-1:0] exp_other;  // non-owner rdata
    } vec_t;

    task automatic run_vec(input vec_t v, input int n);
        int i, p, q, done_at;
        bit other_done;
        i = v.inst; p = v.port; q = 1 - v.port;
        req_i[i][p] = 1'b1; op_i[i][p] = v.op; addr_i[i][p] = v.addr; wdata_i[i][p] = v.wdata;
        step();
        chk($sformatf("v%0d gnt", n), gnt_o[i][p], 1);
        chk($sformatf("v%0d gnt_other", n), gnt_o[i][q], 0);
        chk($sformatf("v%0d mem_en", n), mem_en_o[i], 1);
        chk($sformatf("v%0d mem_op", n), mem_op_o[i], v.op);
        chk($sformatf("v%0d mem_addr", n), mem_addr_o[i], v.addr);
        if (v.op) chk($sformatf("v%0d mem_wb", n), mem_wb_o[i], v.wdata);
        req_i[i][p] = 1'b0;
        done_at = -1;
        other_done = 0;
        for (int c = 1; c <= 40; c++) begin
            chk($sformatf("v%0d busy c%0d", n, c), busy_o[i], 1);
            if (c > 1) chk($sformatf("v%0d mem_en_low c%0d", n, c), mem_en_o[i], 0);
            if (done_o[i][q]) other_done = 1;
            if (done_o[i][p]) begin
                done_at = c;
                break;
            end
            step();
        end
        chk($sformatf("v%0d done_cycle", n), W'(done_at), W'(v.exp_done));
        chk($sformatf("v%0d rdata", n), rdata_o[i][p], v.exp_rdata);
        chk($sformatf("v%0d rdata_other", n), rdata_o[i][q], v.exp_other);
        chk($sformatf("v%0d other_done", n), other_done, 0);
        repeat (3) step();
    endtask

    task automatic pulse_reset(input int i);
        rst[i] = 1'b1;
        step();
        rst[i] = 1'b0;
    endtask

    task automatic rand_driver(input int p, input int n, output int fin);
        int gap, k;
        for (int t = 0; t < n; t++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            op_i[0][p]    = 1'($urandom_range(0, 1));
            addr_i[0][p]  = W'($urandom_range(0, 15));
            wdata_i[0][p] = {$urandom, $urandom};
            req_i[0][p]   = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                step();                 // one-cycle pulse, may or may not be seen
                req_i[0][p] = 1'b0;
            end else begin
                k = 0;
                do begin
                    step();
                    k++;
                end while (!gnt_o[0][p] && k < 64);
                if (!gnt_o[0][p]) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_gnt_timeout port%0d: actual=no_gnt required=gnt", p);
                end
                req_i[0][p] = 1'b0;
            end
        end
        step();
        fin = 1;
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[7];
    int   got_q[$];
    int   cnt_done[2];
    int   fin0, fin1;

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                req_i[i][p] = 1'b0; op_i[i][p] = 1'b0; addr_i[i][p] = '0; wdata_i[i][p] = '0;
            end
        end
        vecs[0] = '{0, 1, 1'b1, 64'd9, 64'hDEADBEEF, 2, 64'd0,         64'd0};
        vecs[1] = '{0, 1, 1'b0, 64'd9, 64'd0,        3, 64'hDEADBEEF,  64'd0};
        vecs[2] = '{0, 0, 1'b0, 64'd5, 64'd0,        3, 64'h2A,        64'hDEADBEEF};
        vecs[3] = '{1, 0, 1'b0, 64'd5, 64'd0,        5, 64'h2A,        64'd0};
        vecs[4] = '{2, 0, 1'b0, 64'd5, 64'd0,       17, 64'h2A,        64'd0};
        vecs[5] = '{1, 1, 1'b1, 64'd3, 64'h1234,     2, 64'd0,         64'h2A};
        vecs[6] = '{1, 1, 1'b0, 64'd3, 64'd0,        5, 64'h1234,      64'h2A};

        // Reset state.
        repeat (3) step();
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        step();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst mem_en[%0d]", i), mem_en_o[i], 0);
            chk($sformatf("rst mem_op[%0d]", i), mem_op_o[i], 0);
            chk($sformatf("rst mem_addr[%0d]", i), mem_addr_o[i], 0);
            chk($sformatf("rst mem_wb[%0d]", i), mem_wb_o[i], 0);
            chk($sformatf("rst busy[%0d]", i), busy_o[i], 0);
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rst gnt%0d[%0d]", p, i), gnt_o[i][p], 0);
                chk($sformatf("rst done%0d[%0d]", p, i), done_o[i][p], 0);
                chk($sformatf("rst rdata%0d[%0d]", p, i), rdata_o[i][p], 0);
            end
        end

        // Table-driven single transactions.
        for (int n = 0; n < 7; n++) run_vec(vecs[n], n);

        // Contention: both read continuously after reset -> 0,1,0,1,...
        pulse_reset(0);
        req_i[0][0] = 1'b1; op_i[0][0] = 1'b0; addr_i[0][0] = 64'd5;
        req_i[0][1] = 1'b1; op_i[0][1] = 1'b0; addr_i[0][1] = 64'd9;
        cnt_done[0] = 0; cnt_done[1] = 0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (gnt_o[0][0]) got_q.push_back(0);
            if (gnt_o[0][1]) got_q.push_back(1);
            if (done_o[0][0]) cnt_done[0]++;
            if (done_o[0][1]) cnt_done[1]++;
            if (done_o[0][0] && done_o[0][1]) chk("cont both_done", 1, 0);
        end
        req_i[0][0] = 1'b0; req_i[0][1] = 1'b0;
        chk("cont grant_count", W'(got_q.size()), 5);
        for (int k = 0; k < 5; k++) exp_q.push_back(W'(k % 2));
        for (int k = 0; k < got_q.size() && k < 5; k++)
            chk($sformatf("cont order%0d", k), W'(got_q[k]), exp_q.pop_front());
        exp_q.delete();
        repeat (6) step();
        chk("cont rdata0", rdata_o[0][0], 64'h2A);
        chk("cont rdata1", rdata_o[0][1], 64'hDEADBEEF);
        chk("cont done0_cnt", W'(cnt_done[0]), 2);  // dones at 3,9 in window
        chk("cont done1_cnt", W'(cnt_done[1]), 2);  // dones at 6,12 in window

        // Back-to-back reads at latency 3: mem_en at 1, 6, 11.
        req_i[1][0] = 1'b1; op_i[1][0] = 1'b0; addr_i[1][0] = 64'd5;
        for (int c = 1; c <= 11; c++) begin
            step();
            chk($sformatf("b2b mem_en c%0d", c), mem_en_o[1], (c == 1 || c == 6 || c == 11));
        end
        req_i[1][0] = 1'b0;
        repeat (8) step();

        // Reset during the second WAIT cycle of a latency-3 read.
        req_i[1][0] = 1'b1; addr_i[1][0] = 64'd5;
        step();
        req_i[1][0] = 1'b0;
        step();
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        chk("mid_rst busy", busy_o[1], 0);
        chk("mid_rst mem_en", mem_en_o[1], 0);
        chk("mid_rst rdata0", rdata_o[1][0], 0);
        cnt_done[0] = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_o[1][0] || done_o[1][1]) cnt_done[0]++;
            step();
        end
        chk("mid_rst no_done", W'(cnt_done[0]), 0);
        req_i[1][0] = 1'b1; addr_i[1][0] = 64'd5;
        req_i[1][1] = 1'b1; addr_i[1][1] = 64'd7; op_i[1][1] = 1'b0;
        step();
        chk("mid_rst tie_gnt0", gnt_o[1][0], 1);
        chk("mid_rst tie_gnt1", gnt_o[1][1], 0);
        req_i[1][0] = 1'b0;
        repeat (20) step();
        req_i[1][1] = 1'b0;
        repeat (6) step();
        chk("mid_rst rdata0_after", rdata_o[1][0], 64'h2A);
        chk("mid_rst rdata1_after", rdata_o[1][1], init_word(7));

        // Withdrawn m1 request during an m0 read at latency 15.
        req_i[2][0] = 1'b1; addr_i[2][0] = 64'd5; op_i[2][0] = 1'b0;
        step();
        req_i[2][0] = 1'b0;
        step(); step();
        req_i[2][1] = 1'b1; op_i[2][1] = 1'b0; addr_i[2][1] = 64'd9;
        step();
        req_i[2][1] = 1'b0;
        cnt_done[0] = 0; cnt_done[1] = 0;
        for (int c = 0; c < 25; c++) begin
            if (gnt_o[2][1] || done_o[2][1]) cnt_done[1]++;
            if (done_o[2][0]) cnt_done[0]++;
            step();
        end
        chk("wd m1_activity", W'(cnt_done[1]), 0);
        chk("wd m0_done_cnt", W'(cnt_done[0]), 1);
        chk("wd m1_rdata", rdata_o[2][1], 0);

        // Randomized traffic on the latency-1 instance against a transaction model.
        pulse_reset(0);
        fin0 = 0; fin1 = 0;
        fork
            rand_driver(0, 40, fin0);
            rand_driver(1, 40, fin1);
            begin : monitor
                logic [W-1:0] mref [16];
                logic [W-1:0] exp_rd [2];
                logic [W-1:0] waddr, wwdata;
                logic wop, act_op;
                int win_exp, act_port, done_cyc, last, cyc, win;
                bit act, avail;
                for (int a = 0; a < 16; a++) mref[a] = init_word(a);
                mref[9] = 64'hDEADBEEF;
                exp_rd[0] = '0; exp_rd[1] = '0;
                win_exp = -1; act = 0; last = 1; cyc = 0;
                act_port = 0; act_op = 0; done_cyc = 0; wop = 0; waddr = '0; wwdata = '0;
                while ((fin0 == 0 || fin1 == 0 || act || win_exp >= 0) && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    chk("rnd gnt0", gnt_o[0][0], win_exp == 0);
                    chk("rnd gnt1", gnt_o[0][1], win_exp == 1);
                    chk("rnd mem_en", mem_en_o[0], win_exp >= 0);
                    if (win_exp >= 0) begin
                        chk("rnd mem_op", mem_op_o[0], wop);
                        chk("rnd mem_addr", mem_addr_o[0], waddr);
                        if (wop) chk("rnd mem_wb", mem_wb_o[0], wwdata);
                        act = 1; act_port = win_exp; act_op = wop;
                        done_cyc = cyc + (wop ? 1 : 1 + L0);
                        if (wop) mref[waddr[3:0]] = wwdata;
                        else exp_q.push_back(mref[waddr[3:0]]);
                    end
                    chk("rnd busy", busy_o[0], act);
                    chk("rnd done0", done_o[0][0], act && cyc == done_cyc && act_port == 0);
                    chk("rnd done1", done_o[0][1], act && cyc == done_cyc && act_port == 1);
                    if (act && cyc == done_cyc && !act_op && exp_q.size() > 0)
                        exp_rd[act_port] = exp_q.pop_front();
                    chk("rnd rdata0", rdata_o[0][0], exp_rd[0]);
                    chk("rnd rdata1", rdata_o[0][1], exp_rd[1]);
                    avail = !act || cyc == done_cyc;
                    if (act && cyc == done_cyc) act = 0;
                    win_exp = -1;
                    if (avail && (req_i[0][0] || req_i[0][1])) begin
                        if (req_i[0][0] && req_i[0][1]) win = 1 - last;
                        else win = req_i[0][1] ? 1 : 0;
                        last = win; win_exp = win;
                        wop = op_i[0][win]; waddr = addr_i[0][win]; wwdata = wdata_i[0][win];
                    end
                end
                if (cyc >= 4000) chk("rnd monitor_timeout", 1, 0);
            end
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
